// File: rtl/bounce_generator_pkg.sv
// Shared encodings and LFSR step for the bounce generator and related stimulus blocks.
package bounce_generator_pkg;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_BOUNCE = 2'd1;
   localparam logic [1:0] S_SETTLE = 2'd2;

   localparam logic [15:0] LFSR_MASK = 16'hB400;

   // Galois, shift right: feedback taps applied when the bit shifted out is 1.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
   endfunction

endpackage

// File: rtl/bounce_generator_lfsr16.sv
// 16-bit Galois LFSR advancing once per enabled cycle; a zero seed is replaced by 1.
module lfsr16
   import bounce_generator_pkg::*;
(
   input  logic        clk,
   input  logic        rst_a_p,
   input  logic        en,
   input  logic [15:0] seed,
   output logic [15:0] q
);

   always_ff @(posedge clk) begin
      if (rst_a_p)
         q <= (seed == 16'h0000) ? 16'h0001 : seed;
      else if (en)
         q <= lfsr_step(q);
   end

endmodule

// File: rtl/bounce_generator.sv
// Turns a clean level request into a bouncy button waveform: a burst of
// pseudo-random segments ending at the requested level, then a settle hold.
module bounce_generator
   import bounce_generator_pkg::*;
#(
   parameter int          BOUNCE_COUNT    = 3,
   parameter int          MAX_GLITCH_LOG2 = 6,
   parameter int          SETTLE_CYCLES   = 1000,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
)(
   input  logic clk,
   input  logic rst_a_p,
   input  logic start,
   input  logic target_level,
   output logic busy,
   output logic done,
   output logic bounce_out
);

   localparam int TOGGLES = 2*BOUNCE_COUNT + 1;
   localparam int TW      = $clog2(TOGGLES + 1);
   localparam int WW      = MAX_GLITCH_LOG2 + 1;
   localparam int SW      = $clog2(SETTLE_CYCLES + 1);

   logic [1:0]    state;
   logic [WW-1:0] width_cnt;
   logic [TW-1:0] toggle_cnt;
   logic [SW-1:0] settle_cnt;
   logic [15:0]   lfsr_q;
   logic [15:0]   lfsr_nxt;
   logic [WW-1:0] width_nxt;
   logic          seg_load;

   // The width of a new segment comes from the value the LFSR is about to take,
   // so each load both advances the LFSR and uses its fresh state.
   assign lfsr_nxt  = lfsr_step(lfsr_q);
   assign width_nxt = {1'b0, lfsr_nxt[MAX_GLITCH_LOG2-1:0]} + {{(WW-1){1'b0}}, 1'b1};

   assign seg_load = ((state == S_IDLE) && start && (target_level != bounce_out)) ||
                     ((state == S_BOUNCE) && (width_cnt == WW'(1)) &&
                      (toggle_cnt < TW'(TOGGLES)));

   assign busy = (state != S_IDLE);

   lfsr16 u_lfsr (
      .clk     (clk),
      .rst_a_p (rst_a_p),
      .en      (seg_load),
      .seed    (LFSR_SEED),
      .q       (lfsr_q)
   );

   always_ff @(posedge clk) begin
      if (rst_a_p) begin
         state      <= S_IDLE;
         bounce_out <= 1'b0;
         done       <= 1'b0;
         width_cnt  <= '0;
         toggle_cnt <= '0;
         settle_cnt <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (target_level != bounce_out) begin
                     bounce_out <= ~bounce_out;
                     width_cnt  <= width_nxt;
                     toggle_cnt <= TW'(1);
                     state      <= S_BOUNCE;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            S_BOUNCE: begin
               if (width_cnt == WW'(1)) begin
                  // Odd toggle count guarantees the burst ends at the requested level.
                  if (toggle_cnt < TW'(TOGGLES)) begin
                     bounce_out <= ~bounce_out;
                     width_cnt  <= width_nxt;
                     toggle_cnt <= toggle_cnt + TW'(1);
                  end else begin
                     width_cnt  <= '0;
                     settle_cnt <= '0;
                     state      <= S_SETTLE;
                  end
               end else begin
                  width_cnt <= width_cnt - WW'(1);
               end
            end
            S_SETTLE: begin
               if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                  settle_cnt <= '0;
                  toggle_cnt <= '0;
                  done       <= 1'b1;
                  state      <= S_IDLE;
               end else begin
                  settle_cnt <= settle_cnt + SW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
